if_fetch: RTL

Instruction fetch stage sitting directly upstream of the decode stage. Fetches 32-bit RV32I instructions from the 8-bit memory-controller port as four little-endian byte reads. Presents each assembled instruction with its PC to decode through a one-entry output buffer with a valid/ready handshake. Stalls after any control-transfer instruction until decode returns the resolved next PC on its branch flag/jump address outputs.

---
 rtl/if_fetch.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// ----------------------------------------------------------------------------
// if_fetch -- RV32I instruction fetch stage in front of decode.
//
// Assembles each 32-bit instruction from four little-endian byte reads on an
// 8-bit memory port and presents it with its PC in a one-entry output buffer
// (valid/ready). Fetching stops after any control-transfer instruction
// (branch / JAL / JALR) until decode supplies the resolved next PC.
//
// Ports
//   clk            clock, rising-edge
//   rst            asynchronous active-low reset
//   mem_req_o      byte read request
//   mem_addr_o     byte address of the request (held until granted)
//   mem_gnt_i      request accepted; byte returns on mem_data_i next cycle
//   mem_data_i     returned byte
//   inst_valid_o   output buffer holds an instruction
//   inst_o, pc_o   buffered instruction and its PC
//   id_ready_i     decode accepts the buffered instruction
//   branch_flag_i  redirect from decode (honoured only while waiting on a
//                  control instruction)
//   jump_addr_i    redirect target
// ----------------------------------------------------------------------------
// State table
//   state     | meaning
//   FETCH     | issuing byte requests / collecting returned bytes
//   HOLD      | four bytes assembled, output buffer busy; no requests
//   WAIT_CTRL | control instruction loaded; no requests until redirect
// ----------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i,
  input  logic        branch_flag_i,
  input  logic [31:0] jump_addr_i
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HOLD      = 2'd1,
    WAIT_CTRL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        run_q;
  logic [31:0] fpc_q, fpc_d;
  logic [2:0]  req_cnt_q, req_cnt_d;
  logic [2:0]  rcv_cnt_q, rcv_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic        in_flight_q, in_flight_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;

  logic        req;
  logic        grant;
  logic        complete;
  logic        buf_free;
  logic        do_load;
  logic [31:0] new_word;

  function automatic logic is_ctrl(input logic [6:0] opcode);
    return (opcode == 7'b1100011) || (opcode == 7'b1101111) ||
           (opcode == 7'b1100111);
  endfunction

  // run_q keeps the request low for the cycle in which reset releases, so the
  // first request appears in the cycle after that edge.
  assign req      = run_q && (state_q == FETCH) && (req_cnt_q < 3'd4);
  assign grant    = req && mem_gnt_i;
  assign complete = in_flight_q && (rcv_cnt_q == 3'd3);
  assign buf_free = !valid_q || id_ready_i;
  // In FETCH the last byte is still on the bus; in HOLD it is already stored.
  assign new_word = (state_q == HOLD) ? asm_q : {mem_data_i, asm_q[23:0]};
  assign do_load  = ((state_q == FETCH && complete) || state_q == HOLD) && buf_free;

  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    req_cnt_d   = req_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    asm_d       = asm_q;
    valid_d     = valid_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    // At most one byte is ever outstanding, so this is just the last grant.
    in_flight_d = grant;

    if (valid_q && id_ready_i) valid_d = 1'b0;

    if (grant) req_cnt_d = req_cnt_q + 3'd1;

    if (in_flight_q) begin
      unique case (rcv_cnt_q[1:0])
        2'd0: asm_d[7:0]   = mem_data_i;
        2'd1: asm_d[15:8]  = mem_data_i;
        2'd2: asm_d[23:16] = mem_data_i;
        2'd3: asm_d[31:24] = mem_data_i;
      endcase
      rcv_cnt_d = rcv_cnt_q + 3'd1;
    end

    unique case (state_q)
      FETCH: begin
        if (complete && !buf_free) state_d = HOLD;
      end
      HOLD: begin
      end
      WAIT_CTRL: begin
        if (branch_flag_i) begin
          fpc_d   = jump_addr_i & ~32'd3;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    if (do_load) begin
      inst_d    = new_word;
      pc_d      = fpc_q;
      valid_d   = 1'b1;
      fpc_d     = fpc_q + 32'd4;
      req_cnt_d = 3'd0;
      rcv_cnt_d = 3'd0;
      state_d   = is_ctrl(new_word[6:0]) ? WAIT_CTRL : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      run_q       <= 1'b0;
      fpc_q       <= RESET_PC;
      req_cnt_q   <= 3'd0;
      rcv_cnt_q   <= 3'd0;
      asm_q       <= 32'd0;
      in_flight_q <= 1'b0;
      valid_q     <= 1'b0;
      inst_q      <= NOP;
      pc_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      run_q       <= 1'b1;
      fpc_q       <= fpc_d;
      req_cnt_q   <= req_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      asm_q       <= asm_d;
      in_flight_q <= in_flight_d;
      valid_q     <= valid_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
    end
  end

  assign mem_req_o    = req;
  assign mem_addr_o   = fpc_q + {29'd0, req_cnt_q};
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_q;

endmodule
